psum_add_ctrl: RTL and testbench
================================

// Module: psum_add_ctrl
// PURPOSE
// Sequencer for the 3-stage psum adder tree of the 3x3 conv kernel. Tracks each PE
// result through the fixed adder pipeline. Drives the psum FIFO read, write and
// zero-select so that input channel 0 starts from zero and channels 1..C-2 accumulate
// through the FIFO. The final channel's sums go to the output instead of the FIFO.
// It sits between the PE-array valid strobe and the psum FIFO / output writer.
// PARAMETERS
// W_BITS   8   width of cfg_width and col_idx; row width of 1..2^W_BITS-1 pixels
// C_BITS   10  width of cfg_chans and ch_idx; channel count of 1..2^C_BITS-1
// PORTS
// clk        in   1       clock, all state on rising edge
// rst_n      in   1       async active-low reset
// start      in   1       1-cycle pulse, begin a row job (sampled only in IDLE)
// cfg_width  in   W_BITS  pixels per row W, latched on accepted start
// cfg_chans  in   C_BITS  input channels C, latched on accepted start
// pe_valid   in   1       pe0/pe1/pe2 data valid this cycle (gaps allowed)
// fifo_empty in   1       psum FIFO empty flag
// fifo_full  in   1       psum FIFO full flag
// busy       out  1       high in RUN and DRAIN
// done       out  1       1-cycle pulse when the job is complete
// col_idx    out  W_BITS  column of the next accepted pe_valid
// ch_idx     out  C_BITS  channel of the next accepted pe_valid
// fifo_rd_en out  1       sync FIFO read; data is on fifo_data the next cycle
// fifo_zero  out  1       force the adder's fifo_data operand to 0 this cycle
// fifo_wr_en out  1       write adder out to the psum FIFO this cycle
// out_valid  out  1       adder out is a final (last-channel) psum this cycle
// err        out  1       sticky: FIFO read while empty, or write while full
// BEHAVIOUR
// - Reset: every output is 0; state=IDLE; counters, tokens and config regs cleared.
// - Adder timing: pe data valid in cycle t -> psum2 valid in t+2 -> adder out valid in t+3.
//   The adder has no enable, so the controller keeps a 3-deep token shift reg v1..v3.
//   Each token carries tags {first = ch==0, last = ch==C-1}.
// - Token entry: a token enters v1 only when pe_valid=1 in RUN. In IDLE, DRAIN and DONE,
//   pe_valid is ignored.
// - fifo_rd_en = v1 & ~first, issued in cycle t+1 so FIFO data lands in cycle t+2.
// - fifo_zero  = v2 & first, in cycle t+2.
// - fifo_wr_en = v3 & ~last, in cycle t+3.
// - out_valid  = v3 & last, in cycle t+3.
// - C=1: first and last are both set, so fifo_rd_en and fifo_wr_en are never asserted.
// - FSM IDLE: on start, latch cfg and go to RUN. start with cfg_width=0 or cfg_chans=0
//   sets err and stays in IDLE.
// - FSM RUN: each accepted pe_valid increments col_idx. At col_idx=W-1, col_idx wraps
//   to 0 and ch_idx increments. Accepting (W-1, C-1) moves to DRAIN.
// - FSM DRAIN: wait until v1..v3 are all 0 (3 cycles), then go to DONE.
// - FSM DONE: assert done for 1 cycle, clear col_idx and ch_idx, return to IDLE.
// - start while busy or in DONE is ignored, with no effect on err.
// - err: set when fifo_rd_en & fifo_empty or when fifo_wr_en & fifo_full. Both
//   checks are done in the same cycle the strobe is asserted. err is cleared only
//   by reset; operation continues.
// - FIFO depth must be at least W; the controller does no flow control on the PEs.
// - Reset mid-job: the pipeline tokens are dropped immediately with no trailing
//   strobes. FIFO contents are the FIFO owner's concern.
// TESTING
// - W=4, C=1, 4 back-to-back pe_valid at t=0..3 -> fifo_zero at t=2..5,
//   out_valid at t=3..6, no rd/wr strobes, done at t=7.
// - W=2, C=3, continuous pe_valid -> 2 zero+wr, then 2 rd+wr, then 2 rd+out_valid.
//   Every rd strobe is exactly 1 cycle before its matching psum2 cycle.
// - W=3, C=2, pe_valid toggling 1/0 -> col_idx and ch_idx advance only on valid,
//   tokens are spaced to match, and done comes 3 cycles after drain starts.
// - fifo_empty held 1 during channel 1 with C=2 -> err rises at the first rd strobe
//   and stays high through done.
// - Assert rst_n low mid-RUN with tokens in flight -> all outputs 0 next cycle and
//   no later strobes. A new start then runs normally.
// - start pulsed during RUN, and start with cfg_chans=0 in IDLE -> the first is
//   ignored; the second sets err and leaves state at IDLE.

Source files
------------

// File: rtl/psum_add_ctrl.sv
// -----------------------------------------------------------------------------
// psum_add_ctrl
//   Sequencer for the 3-stage psum adder tree of the 3x3 conv kernel. Every
//   accepted PE result is followed through the fixed adder pipeline by a token.
//   The token drives the psum FIFO read, the zero-select and the FIFO write, so
//   that input channel 0 starts from zero and later channels accumulate through
//   the FIFO. The final channel's sums are flagged on out_valid instead.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   start                  1-cycle job start, sampled only in IDLE
//   cfg_width, cfg_chans   row width W and channel count C, latched on start
//   pe_valid               PE array result valid (gaps allowed)
//   fifo_empty, fifo_full  psum FIFO status flags
//   busy                   high while running or draining
//   done                   1-cycle pulse at job completion
//   col_idx, ch_idx        column / channel of the next accepted pe_valid
//   fifo_rd_en             FIFO read (data appears the following cycle)
//   fifo_zero              force the adder's FIFO operand to zero
//   fifo_wr_en             write the adder output to the FIFO
//   out_valid              adder output is a final psum
//   err                    sticky: bad config, read while empty, write while full
// -----------------------------------------------------------------------------
module psum_add_ctrl #(
    parameter int W_BITS = 8,
    parameter int C_BITS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W_BITS-1:0] cfg_width,
    input  logic [C_BITS-1:0] cfg_chans,
    input  logic              pe_valid,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic              busy,
    output logic              done,
    output logic [W_BITS-1:0] col_idx,
    output logic [C_BITS-1:0] ch_idx,
    output logic              fifo_rd_en,
    output logic              fifo_zero,
    output logic              fifo_wr_en,
    output logic              out_valid,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [W_BITS-1:0] width_r;
    logic [C_BITS-1:0] chans_r;
    logic [W_BITS-1:0] col_r;
    logic [C_BITS-1:0] ch_r;
    logic              err_r;

    // Token shift register: stage n is valid n cycles after the PE strobe.
    logic [2:0] tok_v;
    logic [2:0] tok_first;
    logic [2:0] tok_last;

    logic accept;
    logic col_last;
    logic ch_first;
    logic ch_last;
    logic cfg_bad;
    logic err_set;

    always_comb begin
        accept   = (state == S_RUN) && pe_valid;
        col_last = (col_r == width_r - W_BITS'(1));
        ch_first = (ch_r == '0);
        ch_last  = (ch_r == chans_r - C_BITS'(1));
        cfg_bad  = (cfg_width == '0) || (cfg_chans == '0);
    end

    // Strobes decode straight from registered tokens, so they are glitch-free
    // and drop to zero the moment reset asserts.
    always_comb begin
        fifo_rd_en = tok_v[0] & ~tok_first[0];
        fifo_zero  = tok_v[1] &  tok_first[1];
        fifo_wr_en = tok_v[2] & ~tok_last[2];
        out_valid  = tok_v[2] &  tok_last[2];
        busy       = (state == S_RUN) || (state == S_DRAIN);
        done       = (state == S_DONE);
        col_idx    = col_r;
        ch_idx     = ch_r;
        err        = err_r;
    end

    always_comb begin
        err_set = (fifo_rd_en & fifo_empty) | (fifo_wr_en & fifo_full);
        if ((state == S_IDLE) && start && cfg_bad) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_v     <= '0;
            tok_first <= '0;
            tok_last  <= '0;
        end else begin
            tok_v     <= {tok_v[1:0], accept};
            tok_first <= {tok_first[1:0], ch_first};
            tok_last  <= {tok_last[1:0], ch_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (err_set) begin
            err_r <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            width_r <= '0;
            chans_r <= '0;
            col_r   <= '0;
            ch_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !cfg_bad) begin
                        width_r <= cfg_width;
                        chans_r <= cfg_chans;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (pe_valid) begin
                        if (col_last) begin
                            col_r <= '0;
                            ch_r  <= ch_r + C_BITS'(1);
                            if (ch_last) begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            col_r <= col_r + W_BITS'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // No entries in DRAIN: once v1 and v2 are clear, the last
                    // token leaves v3 this cycle and the pipe is empty next.
                    if (!tok_v[0] && !tok_v[1]) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    col_r <= '0;
                    ch_r  <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_psum_add_ctrl
//   Scoreboard bench for psum_add_ctrl. Each accepted PE strobe pushes a token
//   (acceptance cycle plus first/last tags) onto a queue; every cycle the
//   expected FIFO strobes are derived from the tokens that are 1, 2 or 3 cycles
//   old and compared with the DUT, and tokens are popped once retired.
// -----------------------------------------------------------------------------
module tb_psum_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_width = '0;
    logic [9:0] cfg_chans = '0;
    logic       pe_valid = 1'b0;
    logic       fifo_empty = 1'b0;
    logic       fifo_full = 1'b0;
    logic       busy, done, fifo_rd_en, fifo_zero, fifo_wr_en, out_valid, err;
    logic [7:0] col_idx;
    logic [9:0] ch_idx;

    psum_add_ctrl #(.W_BITS(8), .C_BITS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_chans  (cfg_chans),
        .pe_valid   (pe_valid),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .done       (done),
        .col_idx    (col_idx),
        .ch_idx     (ch_idx),
        .fifo_rd_en (fifo_rd_en),
        .fifo_zero  (fifo_zero),
        .fifo_wr_en (fifo_wr_en),
        .out_valid  (out_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        bit first;
        bit last;
    } tok_t;

    tok_t tq[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   m_state = 0;   // 0 idle, 1 run, 2 drain, 3 done
    int   m_w = 0;
    int   m_c = 0;
    int   m_col = 0;
    int   m_ch = 0;
    bit   m_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs_zero();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_col", 32'(col_idx), 0);
        check("rst_ch", 32'(ch_idx), 0);
        check("rst_rd", 32'(fifo_rd_en), 0);
        check("rst_zero", 32'(fifo_zero), 0);
        check("rst_wr", 32'(fifo_wr_en), 0);
        check("rst_out", 32'(out_valid), 0);
        check("rst_err", 32'(err), 0);
    endtask

    // One clock: compare this cycle's outputs at the falling edge, then drive
    // the inputs for the coming rising edge and advance the model.
    task automatic cycle(input logic s, input int w, input int c, input logic pv,
                         input logic fe, input logic ff);
        logic e_rd, e_zero, e_wr, e_out;
        bit   err_n;
        @(negedge clk);
        e_rd = 0; e_zero = 0; e_wr = 0; e_out = 0;
        foreach (tq[k]) begin
            if (tq[k].t == cyc - 1 && !tq[k].first) e_rd = 1;
            if (tq[k].t == cyc - 2 && tq[k].first) e_zero = 1;
            if (tq[k].t == cyc - 3) begin
                e_wr  = !tq[k].last;
                e_out = tq[k].last;
            end
        end
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(e_rd));
        check("fifo_zero", 32'(fifo_zero), 32'(e_zero));
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
        check("out_valid", 32'(out_valid), 32'(e_out));
        check("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
        check("done", 32'(done), 32'(m_state == 3));
        check("err", 32'(err), 32'(m_err));
        if (m_state <= 1) begin
            check("col_idx", 32'(col_idx), 32'(m_col));
            check("ch_idx", 32'(ch_idx), 32'(m_ch));
        end

        start = s;
        cfg_width = w[7:0];
        cfg_chans = c[9:0];
        pe_valid = pv;
        fifo_empty = fe;
        fifo_full = ff;

        err_n = m_err | (e_rd & fe) | (e_wr & ff);
        while (tq.size() > 0 && tq[0].t <= cyc - 3) tq.delete(0);
        case (m_state)
            0: if (s) begin
                if (w == 0 || c == 0) err_n = 1;
                else begin
                    m_w = w; m_c = c; m_state = 1;
                end
            end
            1: if (pv) begin
                tq.push_back('{cyc, m_ch == 0, m_ch == m_c - 1});
                if (m_col == m_w - 1) begin
                    m_col = 0;
                    if (m_ch == m_c - 1) m_state = 2;
                    m_ch++;
                end else m_col++;
            end
            2: if (tq.size() == 0) m_state = 3;
            default: begin
                m_col = 0; m_ch = 0; m_state = 0;
            end
        endcase
        m_err = err_n;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        pe_valid = 1'b0;
        fifo_empty = 1'b0;
        fifo_full = 1'b0;
        #1;
        check_outputs_zero();
        tq.delete();
        m_state = 0; m_w = 0; m_c = 0; m_col = 0; m_ch = 0; m_err = 0;
        cyc++;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    // mode 0: pe_valid held high; mode 1: pe_valid toggles 1/0.
    // poke: pulse start with a different config while the job runs.
    task automatic run_job(input int w, input int c, input int mode,
                           input logic fe, input logic ff, input bit poke);
        logic pv;
        bit   sp;
        cycle(1'b1, w, c, 1'b0, fe, ff);
        for (int i = 0; i < 500 && m_state != 0; i++) begin
            pv = (mode == 0) ? 1'b1 : logic'(i % 2 == 0);
            sp = poke && (i == 2);
            cycle(sp, sp ? 1 : w, sp ? 1 : c, pv, fe, ff);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, w, c, 1'b0, fe, ff);
    endtask

    initial begin
        do_reset();
        cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        run_job(4, 1, 0, 1'b0, 1'b0, 1'b0);   // single channel: zero + out only
        run_job(2, 3, 0, 1'b0, 1'b0, 1'b0);   // zero/wr, rd/wr, rd/out
        run_job(3, 2, 1, 1'b0, 1'b0, 1'b0);   // gapped pe_valid
        run_job(5, 2, 0, 1'b0, 1'b0, 1'b1);   // start ignored while busy
        run_job(1, 1, 0, 1'b0, 1'b0, 1'b0);   // 1-pixel row

        // Reset with tokens in flight, then a clean job.
        cycle(1'b1, 4, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4, 2, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 4, 2, 1'b0, 1'b0, 1'b0);
        run_job(2, 1, 0, 1'b0, 1'b0, 1'b0);

        // Zero-config starts in IDLE: err set, no job launched.
        cycle(1'b1, 3, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3, 0, 1'b1, 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 2, 1'b1, 1'b0, 1'b0);

        // FIFO empty during the accumulate channel: err at the first read.
        do_reset();
        run_job(2, 2, 0, 1'b1, 1'b0, 1'b0);
        run_job(2, 2, 0, 1'b0, 1'b0, 1'b0);   // err stays sticky

        // FIFO full during the write channel: err at the first write.
        do_reset();
        run_job(3, 2, 1, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
